// File: rtl/request_reader_if.sv
// request_reader_if: request-memory / motion-controller side signals of request_reader.
// timeout_err exists only when REQ_READER_TIMEOUT_EN is defined.
interface request_reader_if #(
  parameter int unsigned FLOORS = 8,
  parameter int unsigned IDX_W  = 3
);
  logic [FLOORS-1:0] req_vec;
  logic [IDX_W-1:0]  cur_floor;
  logic              floor_ready;
  logic [IDX_W-1:0]  floor_out;
  logic              floor_valid;
  logic              dir_up;
  logic [FLOORS-1:0] pending;
  logic [7:0]        served_cnt;
`ifdef REQ_READER_TIMEOUT_EN
  logic              timeout_err;

  // Reader side: consumes requests and ready, drives the offer.
  modport master (
    input  req_vec, cur_floor, floor_ready,
    output floor_out, floor_valid, dir_up, pending, served_cnt, timeout_err
  );

  // Controller / request-memory side.
  modport slave (
    output req_vec, cur_floor, floor_ready,
    input  floor_out, floor_valid, dir_up, pending, served_cnt, timeout_err
  );
`else
  // Reader side: consumes requests and ready, drives the offer.
  modport master (
    input  req_vec, cur_floor, floor_ready,
    output floor_out, floor_valid, dir_up, pending, served_cnt
  );

  // Controller / request-memory side.
  modport slave (
    output req_vec, cur_floor, floor_ready,
    input  floor_out, floor_valid, dir_up, pending, served_cnt
  );
`endif
endinterface

// File: rtl/request_reader.sv
// request_reader: accumulates floor requests in a sticky vector and offers them one at a
// time to the motion controller in SCAN (elevator sweep) order.
// Optional offer timeout: define REQ_READER_TIMEOUT_EN.
module request_reader #(
  parameter int unsigned FLOORS  = 8,
  parameter int unsigned IDX_W   = 3,
  parameter int unsigned TIMEOUT = 255
) (
  input logic              clk,
  input logic              reset,
  request_reader_if.master bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_OFFER = 2'd2;

  localparam logic [IDX_W-1:0] LAST_FLOOR = IDX_W'(FLOORS - 1);

  // Reject configurations the pointer or the timeout counter cannot represent.
  if (FLOORS < 2 || (64'd1 << IDX_W) < 64'(FLOORS) || TIMEOUT == 0) begin : g_bad_cfg
    $error("request_reader: invalid FLOORS/IDX_W/TIMEOUT combination");
  end

  logic [1:0]        state, state_nxt;
  logic [IDX_W-1:0]  ptr, ptr_nxt;
  logic              dir, dir_nxt;
  logic [FLOORS-1:0] pend, pend_nxt;
  logic              valid, valid_nxt;
  logic [7:0]        served, served_nxt;
  logic [FLOORS-1:0] clr_c;
  logic              accept_c;
  logic              at_end_c;

`ifdef REQ_READER_TIMEOUT_EN
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  logic [WAIT_W-1:0] wait_cnt, wait_nxt;
  logic              timeout, timeout_nxt;
`endif

  // State and output registers; synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      dir      <= 1'b1;
      pend     <= '0;
      valid    <= 1'b0;
      served   <= '0;
`ifdef REQ_READER_TIMEOUT_EN
      wait_cnt <= '0;
      timeout  <= 1'b0;
`endif
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      dir      <= dir_nxt;
      pend     <= pend_nxt;
      valid    <= valid_nxt;
      served   <= served_nxt;
`ifdef REQ_READER_TIMEOUT_EN
      wait_cnt <= wait_nxt;
      timeout  <= timeout_nxt;
`endif
    end
  end

  // Next state: sticky request update, one-floor-per-cycle sweep, offer/accept handling.
  always_comb begin
    state_nxt  = state;
    ptr_nxt    = ptr;
    dir_nxt    = dir;
    served_nxt = served;
    clr_c      = '0;
    at_end_c   = dir ? (ptr == LAST_FLOOR) : (ptr == '0);
    accept_c   = (state == ST_OFFER) && bus.floor_ready;
`ifdef REQ_READER_TIMEOUT_EN
    wait_nxt    = wait_cnt;
    timeout_nxt = 1'b0;
`endif

    // The accepted floor's clear beats a same-cycle request for it.
    if (accept_c) begin
      clr_c = FLOORS'(1) << ptr;
    end
    pend_nxt = (pend | bus.req_vec) & ~clr_c;

    case (state)
      ST_IDLE: begin
        if (pend != '0) begin
          ptr_nxt   = bus.cur_floor;
          state_nxt = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (pend == '0) begin
          state_nxt = ST_IDLE;
        end else if (pend[ptr]) begin
          state_nxt = ST_OFFER;
`ifdef REQ_READER_TIMEOUT_EN
          wait_nxt  = '0;
`endif
        end else if (at_end_c) begin
          dir_nxt = ~dir;
        end else begin
          ptr_nxt = dir ? ptr + 1'b1 : ptr - 1'b1;
        end
      end
      ST_OFFER: begin
        if (accept_c) begin
          served_nxt = served + 8'd1;
          state_nxt  = (pend_nxt != '0) ? ST_SCAN : ST_IDLE;
        end
`ifdef REQ_READER_TIMEOUT_EN
        // Abandon a stalled offer: keep the request, move one floor on and resume sweeping.
        else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          timeout_nxt = 1'b1;
          state_nxt   = ST_SCAN;
          if (at_end_c) begin
            dir_nxt = ~dir;
          end else begin
            ptr_nxt = dir ? ptr + 1'b1 : ptr - 1'b1;
          end
        end else begin
          wait_nxt = wait_cnt + 1'b1;
        end
`endif
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase

    valid_nxt = (state_nxt == ST_OFFER);
  end

  assign bus.floor_out   = ptr;
  assign bus.floor_valid = valid;
  assign bus.dir_up      = dir;
  assign bus.pending     = pend;
  assign bus.served_cnt  = served;
`ifdef REQ_READER_TIMEOUT_EN
  assign bus.timeout_err = timeout;
`endif

endmodule

// File: tb/tb_request_reader.sv
// tb_request_reader: random request/ready traffic against a sweep-order reference model,
// plus directed reset, re-request-across-accept and reset-mid-offer cases.
module tb_request_reader;

  localparam int unsigned F  = 8;
  localparam int unsigned IW = 3;
  localparam int          TO = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  request_reader_if #(.FLOORS(F), .IDX_W(IW)) bus ();

  request_reader #(.FLOORS(F), .IDX_W(IW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp;
  int n_bad;

  // Count one comparison and report it if it differs.
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Next floor in elevator order from position p heading d, and the number of
  // one-floor-per-cycle scan steps it takes (a reversal costs one extra step).
  function automatic void sweep(input int p, input bit d, input logic [F-1:0] pv,
                                output int f, output bit nd, output int c);
    f = p; nd = d; c = 1;
    if (d) begin
      for (int i = p; i < int'(F); i++) if (pv[i]) begin f = i; nd = 1'b1; c = i - p + 1; return; end
      for (int i = int'(F) - 1; i >= 0; i--) if (pv[i]) begin f = i; nd = 1'b0; c = 2 * int'(F) - p - i; return; end
    end else begin
      for (int i = p; i >= 0; i--) if (pv[i]) begin f = i; nd = 1'b0; c = p - i + 1; return; end
      for (int i = 0; i < int'(F); i++) if (pv[i]) begin f = i; nd = 1'b1; c = p + i + 2; return; end
    end
  endfunction

  // Reference model state
  logic [F-1:0] pend_m;
  logic [7:0]   served_m;
  bit           m_valid;
  int           m_floor;
  bit           m_dir;
  int           m_gap;
  int           m_wait;
  bit           m_to;
  int           nf;
  bit           nd;
  int           cur;

  initial begin
    logic [F-1:0] req;
    logic [F-1:0] pn;
    logic [F-1:0] oh;
    bit           rdy;
    bit           acc;

    n_cmp = 0;
    n_bad = 0;

    // Reset held for two edges with every request line high.
    reset           = 1'b0;
    bus.req_vec     = '1;
    bus.floor_ready = 1'b0;
    bus.cur_floor   = '0;
    repeat (2) @(negedge clk);
    check("rst_valid",   32'(bus.floor_valid), 32'd0);
    check("rst_floor",   32'(bus.floor_out),   32'd0);
    check("rst_dir",     32'(bus.dir_up),      32'd1);
    check("rst_pending", 32'(bus.pending),     32'd0);
    check("rst_served",  32'(bus.served_cnt),  32'd0);
`ifdef REQ_READER_TIMEOUT_EN
    check("rst_timeout", 32'(bus.timeout_err), 32'd0);
`endif
    reset       = 1'b1;
    bus.req_vec = '0;
    @(negedge clk);
    check("post_rst_pending", 32'(bus.pending),     32'd0);
    check("post_rst_valid",   32'(bus.floor_valid), 32'd0);

    pend_m = '0; served_m = '0; m_valid = 1'b0; m_floor = 0; m_dir = 1'b1;
    m_gap = 0; m_wait = 0; m_to = 1'b0; nf = 0; nd = 1'b1; cur = 0;

    // Random traffic: new calls arrive while idle or while an offer is up.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      check("pending", 32'(bus.pending),     32'(pend_m));
      check("served",  32'(bus.served_cnt), 32'(served_m));
      check("valid",   32'(bus.floor_valid), 32'(m_valid));
      if (m_valid) begin
        check("floor", 32'(bus.floor_out), 32'(m_floor));
      end
      if (m_valid || m_gap == 0) begin
        check("dir", 32'(bus.dir_up), 32'(m_dir));
      end
`ifdef REQ_READER_TIMEOUT_EN
      check("timeout", 32'(bus.timeout_err), 32'(m_to));
`endif

      req = '0;
      rdy = ($urandom_range(0, 2) == 0);
      if (m_valid) begin
        if ($urandom_range(0, 3) == 0) req = F'($urandom);
      end else if (m_gap == 0 && pend_m == '0 && $urandom_range(0, 2) == 0) begin
        req = F'($urandom) | (F'(1) << $urandom_range(0, F - 1));
        cur = int'($urandom_range(0, F - 1));
      end
      bus.req_vec     = req;
      bus.floor_ready = rdy;
      bus.cur_floor   = IW'(cur);

      // Predict the effect of the coming edge.
      acc  = m_valid && rdy;
      oh   = acc ? (F'(1) << m_floor) : '0;
      pn   = (pend_m | req) & ~oh;
      m_to = 1'b0;
      if (m_valid) begin
        if (rdy) begin
          served_m++;
          m_valid = 1'b0;
          if (pn != '0) sweep(m_floor, m_dir, pn, nf, nd, m_gap);
        end
`ifdef REQ_READER_TIMEOUT_EN
        else if (m_wait == TO - 1) begin
          m_to    = 1'b1;
          m_valid = 1'b0;
          if (m_dir && m_floor == int'(F) - 1)  sweep(m_floor, 1'b0, pn, nf, nd, m_gap);
          else if (!m_dir && m_floor == 0)      sweep(m_floor, 1'b1, pn, nf, nd, m_gap);
          else sweep(m_dir ? m_floor + 1 : m_floor - 1, m_dir, pn, nf, nd, m_gap);
        end else begin
          m_wait++;
        end
`endif
      end else if (m_gap > 0) begin
        m_gap--;
        if (m_gap == 0) begin
          m_valid = 1'b1; m_floor = nf; m_dir = nd; m_wait = 0;
        end
      end else if (pend_m != '0) begin
        sweep(cur, m_dir, pend_m, nf, nd, m_gap);
      end
      pend_m = pn;

      @(negedge clk);
    end

    // Floor 4 requested continuously with ready high: cleared on accept, re-latched next cycle.
    reset = 1'b0; bus.req_vec = '0; bus.floor_ready = 1'b0;
    @(negedge clk);
    reset = 1'b1; bus.cur_floor = 3'd4; bus.req_vec = 8'h10; bus.floor_ready = 1'b1;
    @(negedge clk);
    check("hold_e0_pending", 32'(bus.pending),     32'h10);
    check("hold_e0_valid",   32'(bus.floor_valid), 32'd0);
    @(negedge clk);
    check("hold_e1_valid",   32'(bus.floor_valid), 32'd0);
    @(negedge clk);
    check("hold_e2_valid",   32'(bus.floor_valid), 32'd1);
    check("hold_e2_floor",   32'(bus.floor_out),   32'd4);
    @(negedge clk);
    check("hold_acc_valid",  32'(bus.floor_valid), 32'd0);
    check("hold_acc_pend",   32'(bus.pending),     32'd0);
    check("hold_acc_served", 32'(bus.served_cnt),  32'd1);
    @(negedge clk);
    check("hold_relatch",    32'(bus.pending),     32'h10);
    @(negedge clk);
    check("hold_e5_valid",   32'(bus.floor_valid), 32'd0);
    @(negedge clk);
    check("hold_reoffer",    32'(bus.floor_valid), 32'd1);
    check("hold_refloor",    32'(bus.floor_out),   32'd4);

    // Reset during an offer drops it and all pending requests.
    reset = 1'b0; bus.req_vec = 8'h00;
    @(negedge clk);
    check("rst_offer_valid",  32'(bus.floor_valid), 32'd0);
    check("rst_offer_pend",   32'(bus.pending),     32'd0);
    check("rst_offer_served", 32'(bus.served_cnt),  32'd0);
    reset = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
